// File: rtl/zb_tx_pkg.sv
// rtl/zb_tx_pkg.sv - shared types, constants and PN mapping for the ZigBee chip spreader
//
// Purpose: FSM state type, symbol geometry and the 802.15.4 O-QPSK PN table,
//          generated from symbol 0 by the rotate/invert rule.
// Ports:   none (package).
package zb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  localparam int ZB_CHIPS_PER_SYMB = 32;

  // Chip c0 is bit 31, so the bit order matches the written chip string.
  localparam logic [31:0] ZB_PN_SYMB0 = 32'b11011001110000110101001000101110;

  // Symbols 1..7 rotate symbol 0 right by 4 chips per step; symbols 8..15
  // additionally invert the odd-indexed chips (bits 30, 28, ... 0).
  function automatic logic [31:0] zb_pn_chips(input logic [3:0] symbol);
    logic [63:0] dbl;
    logic [5:0]  sh;
    logic [31:0] rot;
    dbl = {ZB_PN_SYMB0, ZB_PN_SYMB0};
    sh  = {1'b0, symbol[2:0], 2'b00};
    rot = dbl[sh +: 32];
    if (symbol[3]) begin
      rot = rot ^ 32'h5555_5555;
    end
    return rot;
  endfunction

endpackage

// File: rtl/zb_chip_spreader_if.sv
// rtl/zb_chip_spreader_if.sv - byte input handshake and chip output bundle
//
// Purpose: groups the byte handshake and the chip stream of zb_chip_spreader.
// Signals: i_DATA/i_VALID/o_READY byte handshake; o_CHIP, o_CHIP_EN,
//          o_SYMB_START, o_BUSY chip stream; o_CHIP_I/o_CHIP_Q only when
//          ZB_SPREAD_IQ_EN is defined.
// Modports: master = byte source / chip sink, slave = spreader.
interface zb_chip_spreader_if;
  logic [7:0] i_DATA;
  logic       i_VALID;
  logic       o_READY;
  logic       o_CHIP;
  logic       o_CHIP_EN;
  logic       o_SYMB_START;
  logic       o_BUSY;
`ifdef ZB_SPREAD_IQ_EN
  logic       o_CHIP_I;
  logic       o_CHIP_Q;

  modport master (output i_DATA, i_VALID,
                  input  o_READY, o_CHIP, o_CHIP_EN, o_SYMB_START, o_BUSY,
                         o_CHIP_I, o_CHIP_Q);
  modport slave  (input  i_DATA, i_VALID,
                  output o_READY, o_CHIP, o_CHIP_EN, o_SYMB_START, o_BUSY,
                         o_CHIP_I, o_CHIP_Q);
`else
  modport master (output i_DATA, i_VALID,
                  input  o_READY, o_CHIP, o_CHIP_EN, o_SYMB_START, o_BUSY);
  modport slave  (input  i_DATA, i_VALID,
                  output o_READY, o_CHIP, o_CHIP_EN, o_SYMB_START, o_BUSY);
`endif
endinterface

// File: rtl/zb_chip_timer.sv
// rtl/zb_chip_timer.sv - per-chip tick counter for the chip spreader
//
// Purpose: counts 0..CLK_PER_CHIP-1 while run is high and flags the first
//          and last clock of every chip.
// Ports:   clk, rst (async, active-high); run = spreader busy;
//          chip_en = first clock of a chip; last = final clock of a chip.
module zb_chip_timer #(
  parameter int CLK_PER_CHIP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic chip_en,
  output logic last
);

  localparam logic [7:0] TICK_LAST = 8'(CLK_PER_CHIP - 1);

  logic [7:0] tick;

  // Held at 0 while idle so the first chip of a new byte starts a full chip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
    end else if (run && (tick != TICK_LAST)) begin
      tick <= tick + 8'd1;
    end else begin
      tick <= '0;
    end
  end

  assign chip_en = run && (tick == 8'd0);
  assign last    = run && (tick == TICK_LAST);

endmodule

// File: rtl/zb_chip_spreader.sv
// rtl/zb_chip_spreader.sv - ZigBee DSSS chip spreader (byte -> 2 x 32 chips)
//
// Purpose: accepts bytes, spreads low then high nibble into PN chips, emits
//          one chip every CLK_PER_CHIP clocks, gapless across bytes.
// Ports:   i_CLK clock; i_RST async active-high reset; bus (slave) carries
//          i_DATA/i_VALID/o_READY and o_CHIP/o_CHIP_EN/o_SYMB_START/o_BUSY.
// Option:  ZB_SPREAD_IQ_EN adds o_CHIP_I (even chips) and o_CHIP_Q (odd chips).
module zb_chip_spreader
  import zb_tx_pkg::*;
#(
  parameter int CLK_PER_CHIP = 4
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  zb_chip_spreader_if.slave  bus
);

  localparam logic [4:0] LAST_CHIP = 5'(ZB_CHIPS_PER_SYMB - 1);

  state_t      state;
  logic [7:0]  byte_q;
  logic [4:0]  chip_idx;
  logic        chip;
  logic        symb_start;
  logic        busy;
  logic        chip_en;
  logic        last;

  zb_chip_timer #(.CLK_PER_CHIP(CLK_PER_CHIP)) u_timer (
    .clk     (i_CLK),
    .rst     (i_RST),
    .run     (busy),
    .chip_en (chip_en),
    .last    (last)
  );

  logic        chip_end;
  logic        ready;
  logic        accept;
  logic [31:0] cur_word;
  logic [31:0] hi_word;
  logic [31:0] new_word;
  logic [4:0]  next_idx;
  logic [4:0]  step_pos;

  assign chip_end = last && (chip_idx == LAST_CHIP);
  // Ready in the final clock of the high symbol lets the next byte follow gaplessly.
  assign ready    = !i_RST && ((state == IDLE) || ((state == SEND_HI) && chip_end));
  assign accept   = bus.i_VALID && ready;
  assign cur_word = zb_pn_chips((state == SEND_HI) ? byte_q[7:4] : byte_q[3:0]);
  assign hi_word  = zb_pn_chips(byte_q[7:4]);
  assign new_word = zb_pn_chips(bus.i_DATA[3:0]);
  assign next_idx = chip_idx + 5'd1;
  assign step_pos = ~next_idx;   // 31 - next_idx: c0 lives in bit 31

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state      <= IDLE;
      byte_q     <= '0;
      chip_idx   <= '0;
      chip       <= 1'b0;
      symb_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      symb_start <= 1'b0;
      case (state)
        IDLE: begin
          chip     <= 1'b0;
          busy     <= 1'b0;
          chip_idx <= '0;
          if (accept) begin
            byte_q     <= bus.i_DATA;
            state      <= SEND_LO;
            chip       <= new_word[31];
            symb_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SEND_LO: begin
          if (chip_end) begin
            state      <= SEND_HI;
            chip_idx   <= '0;
            chip       <= hi_word[31];
            symb_start <= 1'b1;
          end else if (last) begin
            chip_idx <= next_idx;
            chip     <= cur_word[step_pos];
          end
        end
        SEND_HI: begin
          if (chip_end) begin
            chip_idx <= '0;
            if (accept) begin
              byte_q     <= bus.i_DATA;
              state      <= SEND_LO;
              chip       <= new_word[31];
              symb_start <= 1'b1;
            end else begin
              state <= IDLE;
              chip  <= 1'b0;
              busy  <= 1'b0;
            end
          end else if (last) begin
            chip_idx <= next_idx;
            chip     <= cur_word[step_pos];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ZB_SPREAD_IQ_EN
  logic load_first;
  logic load_step;
  logic chip_i;
  logic chip_q;

  // Chip 0 of a symbol is even, so it always lands on the I rail.
  assign load_first = accept || ((state == SEND_LO) && chip_end);
  assign load_step  = (state != IDLE) && last && !chip_end;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      chip_i <= 1'b0;
      chip_q <= 1'b0;
    end else if (load_first) begin
      chip_i <= accept ? new_word[31] : hi_word[31];
    end else if (load_step) begin
      if (next_idx[0]) begin
        chip_q <= cur_word[step_pos];
      end else begin
        chip_i <= cur_word[step_pos];
      end
    end
  end

  assign bus.o_CHIP_I = chip_i;
  assign bus.o_CHIP_Q = chip_q;
`endif

  assign bus.o_READY      = ready;
  assign bus.o_CHIP       = chip;
  assign bus.o_CHIP_EN    = chip_en;
  assign bus.o_SYMB_START = symb_start;
  assign bus.o_BUSY       = busy;

endmodule

// File: tb/tb_zb_chip_spreader.sv
// tb/tb_zb_chip_spreader.sv - directed self-checking bench for zb_chip_spreader
module tb_zb_chip_spreader;

  // Hand-derived PN words, c0 in bit 31.
  localparam logic [31:0] PN0 = 32'hD9C3522E;
  localparam logic [31:0] PN1 = 32'hED9C3522;
  localparam logic [31:0] PN2 = 32'h2ED9C352;
  localparam logic [31:0] PN3 = 32'h22ED9C35;
  localparam logic [31:0] PN5 = 32'h3522ED9C;
  localparam logic [31:0] PN8 = 32'h8C96077B;
  localparam logic [31:0] PNA = 32'h7B8C9607;
  localparam logic [31:0] PNF = 32'hC96077B8;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   hs4;
  int   hs_base;

  zb_chip_spreader_if bus4();
  zb_chip_spreader_if bus1();

  zb_chip_spreader #(.CLK_PER_CHIP(4)) dut4 (.i_CLK(clk), .i_RST(rst), .bus(bus4));
  zb_chip_spreader #(.CLK_PER_CHIP(1)) dut1 (.i_CLK(clk), .i_RST(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus4.i_VALID && bus4.o_READY) hs4 <= hs4 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input bit sel, input logic [7:0] data);
    @(negedge clk);
    if (sel) begin bus1.i_VALID = 1'b1; bus1.i_DATA = data; end
    else     begin bus4.i_VALID = 1'b1; bus4.i_DATA = data; end
    @(posedge clk);
    #1;
    if (sel) bus1.i_VALID = 1'b0;
    else     bus4.i_VALID = 1'b0;
  endtask

  task automatic sample(input bit sel, output logic c, output logic e, output logic s, output logic b);
    c = sel ? bus1.o_CHIP       : bus4.o_CHIP;
    e = sel ? bus1.o_CHIP_EN    : bus4.o_CHIP_EN;
    s = sel ? bus1.o_SYMB_START : bus4.o_SYMB_START;
    b = sel ? bus1.o_BUSY       : bus4.o_BUSY;
  endtask

  // One symbol: chip value per chip, hold, enable/start pulse positions, busy.
  task automatic capture(input bit sel, input int cpc, input logic [31:0] exp_word, input string tag);
    logic [31:0] w;
    int bad;
    logic c, e, s, b;
    w = '0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      for (int t = 0; t < cpc; t++) begin
        @(negedge clk);
        sample(sel, c, e, s, b);
        if (t == 0) w[31-i] = c;
        else if (c !== w[31-i]) bad++;
        if (e !== (t == 0)) bad++;
        if (s !== (i == 0 && t == 0)) bad++;
        if (b !== 1'b1) bad++;
      end
    end
    check({tag, "_chips"}, w, exp_word);
    check({tag, "_timing"}, 32'(bad), 32'd0);
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic c, e, s, b, r;
    @(negedge clk);
    sample(sel, c, e, s, b);
    r = sel ? bus1.o_READY : bus4.o_READY;
    check(tag, 32'({b, c, e, s, r}), 32'h1);
  endtask

`ifdef ZB_SPREAD_IQ_EN
  task automatic check_iq();
    int bad;
    int j;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        if (bus4.o_CHIP_I !== PN0[31 - ((i % 32) & ~1)]) bad++;
        if (i > 0) begin
          j = (i % 2 == 1) ? i : i - 1;
          if (bus4.o_CHIP_Q !== PN0[31 - (j % 32)]) bad++;
        end
      end
    end
    check("iq_rails", 32'(bad), 32'd0);
  endtask
`endif

  initial begin
    total = 0;
    passed = 0;
    hs4 = 0;
    rst = 1'b1;
    bus4.i_VALID = 1'b0; bus4.i_DATA = 8'h00;
    bus1.i_VALID = 1'b0; bus1.i_DATA = 8'h00;

    #2;
    check("reset_outputs", 32'({bus4.o_READY, bus4.o_CHIP, bus4.o_CHIP_EN,
                                bus4.o_SYMB_START, bus4.o_BUSY}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_idle(1'b0, "idle_after_reset");

    // Single byte 0x10: symbol 0 then symbol 1, 256 busy cycles.
    send(1'b0, 8'h10);
    capture(1'b0, 4, PN0, "b10_lo");
    capture(1'b0, 4, PN1, "b10_hi");
    check_idle(1'b0, "b10_idle");

    // Byte 0x08: symbol 8 (odd chips inverted) then symbol 0.
    send(1'b0, 8'h08);
    capture(1'b0, 4, PN8, "b08_lo");
    capture(1'b0, 4, PN0, "b08_hi");
    check_idle(1'b0, "b08_idle");

    // Three back-to-back bytes with valid held high.
    hs_base = hs4;
    @(negedge clk);
    bus4.i_VALID = 1'b1; bus4.i_DATA = 8'h00;
    @(posedge clk); #1; bus4.i_DATA = 8'hFF;
    capture(1'b0, 4, PN0, "s00_lo");
    capture(1'b0, 4, PN0, "s00_hi");
    @(posedge clk); #1; bus4.i_DATA = 8'hA5;
    capture(1'b0, 4, PNF, "sff_lo");
    capture(1'b0, 4, PNF, "sff_hi");
    @(posedge clk); #1; bus4.i_VALID = 1'b0;
    capture(1'b0, 4, PN5, "sa5_lo");
    capture(1'b0, 4, PNA, "sa5_hi");
    check_idle(1'b0, "stream_idle");
    check("stream_handshakes", 32'(hs4 - hs_base), 32'd3);

    // Asynchronous reset at chip 17 of symbol 0, then restart with 0x33.
    send(1'b0, 8'h00);
    repeat (17 * 4 + 1) @(negedge clk);
    check("pre_reset_chip17", 32'({bus4.o_CHIP, bus4.o_CHIP_EN, bus4.o_BUSY}), 32'h7);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_outputs", 32'({bus4.o_READY, bus4.o_CHIP, bus4.o_CHIP_EN,
                                    bus4.o_SYMB_START, bus4.o_BUSY}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 8'h33);
    capture(1'b0, 4, PN3, "b33_lo");
    capture(1'b0, 4, PN3, "b33_hi");
    check_idle(1'b0, "b33_idle");

    // CLK_PER_CHIP=1: enable constantly high for 64 cycles.
    send(1'b1, 8'h21);
    capture(1'b1, 1, PN1, "c1_lo");
    capture(1'b1, 1, PN2, "c1_hi");
    check_idle(1'b1, "c1_idle");

`ifdef ZB_SPREAD_IQ_EN
    send(1'b0, 8'h00);
    check_iq();
    check_idle(1'b0, "iq_idle");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zb_chip_spreader.md
Name: zb_chip_spreader

Overview:
- Transmit-chain DSSS stage of the ZigBee (IEEE 802.15.4, 2.4 GHz O-QPSK) emitter.
- Accepts payload bytes over a valid/ready handshake and splits each byte into two 4-bit symbols, low nibble first.
- Maps each symbol to its 32-chip PN sequence and emits the chips serially at a fixed chip rate.
- Output feeds the O-QPSK stage, where a single-bit register stage produces the half-chip Q offset.

Parameters:
- CLK_PER_CHIP, 4, clock cycles per chip; legal range 1..255; default gives 2 Mchip/s at 8 MHz.

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  asynchronous, active-high reset.
- i_DATA  in  8  payload byte.
- i_VALID  in  1  i_DATA valid.
- o_READY  out  1  block accepts i_DATA this cycle.
- o_CHIP  out  1  current chip value, held for CLK_PER_CHIP cycles.
- o_CHIP_EN  out  1  one-cycle pulse in the first cycle of each chip.
- o_SYMB_START  out  1  one-cycle pulse coincident with o_CHIP_EN of chip 0 of each symbol.
- o_BUSY  out  1  high while chips are being emitted.

Behaviour:
- Interface decided: one clock i_CLK; reset i_RST is asynchronous and active-high.
- Reset values: state IDLE, o_CHIP=0, o_CHIP_EN=0, o_SYMB_START=0, o_BUSY=0, chip and tick counters=0. o_READY=0 while i_RST=1.
- FSM states:
  - IDLE: o_READY=1. On i_VALID&o_READY, latch the byte and go to SEND_LO.
  - SEND_LO: emit 32 chips of symbol i_DATA[3:0], then go to SEND_HI.
  - SEND_HI: emit 32 chips of symbol i_DATA[7:4]. At the end, go to SEND_LO if a new byte was accepted, else IDLE.
- Timing: tick counter runs 0..CLK_PER_CHIP-1. Chip index 0..31 advances when the tick counter wraps.
- Latency:
  - Byte accepted at edge N → chip 0 on o_CHIP, with o_CHIP_EN=1 and o_SYMB_START=1, in the cycle after edge N.
  - One byte lasts 64*CLK_PER_CHIP cycles.
- Gapless streaming:
  - o_READY is also 1 in SEND_HI during the last clock of chip 31.
  - A byte accepted then produces its chip 0 in the very next cycle. No idle cycle between bytes.
- o_READY=0 at all other times in SEND_LO and SEND_HI. i_DATA is sampled only on handshake.
- o_BUSY=1 in SEND_LO and SEND_HI. It stays 1 across back-to-back bytes.
- After the last byte, o_BUSY falls in the cycle after chip 31 ends. o_CHIP returns to 0 in IDLE.
- Chip order: c0 is transmitted first.
- PN table:
  - Symbol 0 (c0..c31) = 11011001110000110101001000101110.
  - Symbol k, k=1..7: symbol 0 cyclically rotated right by 4k chips. Example: symbol 1 = 11101101100111000011010100100010.
  - Symbol k+8: symbol k with odd-indexed chips (c1, c3, …) inverted. Example: symbol 8 = 10001100100101100000011101111011.
- CLK_PER_CHIP=1: o_CHIP_EN is constantly 1 while busy.
- Reset asserted mid-byte: outputs return to reset values immediately (asynchronous). The partial byte is discarded and not resumed.
- i_VALID with o_READY=0: no effect. The upstream source must hold the data.

Optional Feature:
- Macro: ZB_SPREAD_IQ_EN.
- When defined, adds ports o_CHIP_I (out, 1) and o_CHIP_Q (out, 1):
  - Even-indexed chips update o_CHIP_I.
  - Odd-indexed chips update o_CHIP_Q.
  - Each output updates at that chip's o_CHIP_EN and holds for 2*CLK_PER_CHIP cycles.
  - Both reset to 0.
- When undefined: the ports are absent and downstream logic performs the I/Q split from o_CHIP.

Decomposition:
- Package zb_tx_pkg holds:
  - typedef state_t {IDLE, SEND_LO, SEND_HI}.
  - constant ZB_CHIPS_PER_SYMB=32.
  - constant ZB_PN_SYMB0 (32-bit).
  - function zb_pn_chips(symbol) returning the 32-bit sequence by the rotate/invert rule.
- One natural sub-module: zb_chip_timer, the tick counter that generates o_CHIP_EN. The PN mapping stays a package function, not a sub-module.

Test Plan (CLK_PER_CHIP=4 unless noted):
- Reset then a single byte 0x10 → chips 11011001110000110101001000101110 then 11101101100111000011010100100010. Each chip held 4 cycles. o_BUSY high for 256 cycles, then IDLE with o_CHIP=0.
- Byte 0x08 → first symbol 10001100100101100000011101111011. o_SYMB_START pulses at cycles 1 and 129.
- Three bytes 0x00, 0xFF, 0xA5 with i_VALID held high → exactly 3 handshakes, 768 contiguous chip cycles, no gap. Chip streams match zb_pn_chips reference per nibble.
- i_RST pulsed at chip 17 of symbol 0 → outputs zero within the same cycle. The next byte 0x33 restarts from chip 0 of symbol 3.
- CLK_PER_CHIP=1, byte 0x21 → o_CHIP_EN constant 1 for 64 cycles. Symbol 1 then symbol 2 chip sequences.
- With ZB_SPREAD_IQ_EN, byte 0x00 → o_CHIP_I = even chips of symbol 0 (1,0,1,0,…), each held 8 cycles. o_CHIP_Q = odd chips, updating 4 cycles later.
